// File: rtl/if_fetch_unit_if.sv
// Instruction-memory fetch bus: request/grant plus a separate response-valid.
// The fetch unit is the master; the instruction memory is the slave.
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage feeding IF/ID. Owns the PC, keeps at most one
// memory request in flight, and buffers returned words in a small FIFO whose
// head drives IF/ID. Redirect flushes the buffer and retargets the PC; a
// response still in flight at that moment is killed on arrival.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   redirect_i,
    input  logic [31:0]            redirect_target_i,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            instruction_out_o,
    output logic [31:0]            pc_out_o,
    output logic [31:0]            sum_out_o,
    output logic                   fetch_valid_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic          outstanding_q, outstanding_d;
    logic          kill_q, kill_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   instr_mem_q [FIFO_DEPTH];
    logic [31:0]   pc_mem_q    [FIFO_DEPTH];

    logic          head_vld;
    logic          consume;
    logic          resp;
    logic          push;
    logic          req;
    logic          accept;
    logic [CW:0]   occ;

    // Handshake decode: head visibility, pop/push, and the issue rule.
    // occ counts entries the buffer will have to hold if nothing new issues;
    // a returning response in this cycle is already part of it via outstanding.
    always_comb begin
        head_vld = !rst && (count_q != '0);
        consume  = head_vld && !stall_i && !redirect_i;
        resp     = imem.imem_rvalid && outstanding_q;
        push     = resp && !kill_q && !redirect_i && !rst;
        occ      = {1'b0, count_q} + (CW+1)'(outstanding_q) - (CW+1)'(consume);
        req      = !rst && !redirect_i && !kill_q
                   && (!outstanding_q || imem.imem_rvalid)
                   && (occ < (CW+1)'(FIFO_DEPTH));
        accept   = req && imem.imem_gnt;
    end

    // Bus and IF/ID outputs; an empty buffer presents the all-zero bubble.
    always_comb begin
        imem.imem_req     = req;
        imem.imem_addr    = pc_q;
        fetch_valid_o     = head_vld;
        instruction_out_o = '0;
        pc_out_o          = '0;
        sum_out_o         = '0;
        if (head_vld) begin
            instruction_out_o = instr_mem_q[rd_ptr_q];
            pc_out_o          = pc_mem_q[rd_ptr_q];
            sum_out_o         = pc_mem_q[rd_ptr_q] + 32'd4;
        end
    end

    // Next-state: PC, in-flight tracking, kill, and FIFO bookkeeping.
    // Redirect outranks stall and consume and empties the buffer outright.
    always_comb begin
        pc_d          = pc_q;
        req_addr_d    = req_addr_q;
        outstanding_d = outstanding_q;
        kill_d        = kill_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;

        if (accept) begin
            pc_d          = pc_q + 32'd4;
            req_addr_d    = pc_q;
            outstanding_d = 1'b1;
        end else if (resp) begin
            outstanding_d = 1'b0;
        end

        // A pending response retires the kill on arrival; a redirect with a
        // response still in flight (re)arms it.
        if (resp) kill_d = 1'b0;
        if (redirect_i && outstanding_q && !imem.imem_rvalid) kill_d = 1'b1;

        if (redirect_i) begin
            pc_d     = redirect_target_i;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (consume) rd_ptr_d = rd_ptr_q + PW'(1);
            if (push)    wr_ptr_d = wr_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(consume);
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            req_addr_q    <= RESET_PC;
            outstanding_q <= 1'b0;
            kill_q        <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            req_addr_q    <= req_addr_d;
            outstanding_q <= outstanding_d;
            kill_q        <= kill_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Buffer storage; contents are only meaningful below count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= imem.imem_rdata;
            pc_mem_q[wr_ptr_q]    <= req_addr_q;
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a latency-programmable memory model plus
// a per-cycle vector table, followed by reset and PC-wrap sequences.
module tb_if_fetch_unit;
    localparam logic [31:0] K = 32'hA5A5_0000;

    typedef struct {
        bit          st;
        bit          rd;
        logic [31:0] tg;
        bit          g;
        int          l;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_vld;
        logic [31:0] e_pc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] target = '0;
    logic        gnt = 1'b1;
    int          lat = 1;

    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] mem_addr = '0;
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic        proto_err = 1'b0;

    logic [31:0] instr, pc_o, sum_o;
    logic        vld;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    vec_t        tbl[$];

    if_fetch_unit_if bus();
    assign bus.imem_gnt    = gnt;
    assign bus.imem_rvalid = mem_rvalid;
    assign bus.imem_rdata  = mem_rdata;

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .stall_i           (stall),
        .redirect_i        (redirect),
        .redirect_target_i (target),
        .imem              (bus),
        .instruction_out_o (instr),
        .pc_out_o          (pc_o),
        .sum_out_o         (sum_o),
        .fetch_valid_o     (vld)
    );

    always #5 clk = ~clk;

    // Memory: answers each grant after lat cycles with addr ^ K; flags a
    // second grant while one is still in flight.
    always @(posedge clk) begin
        mem_rvalid <= 1'b0;
        if (mem_busy) begin
            if (mem_cnt == 1) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= mem_addr ^ K;
                mem_busy   <= 1'b0;
            end else begin
                mem_cnt <= mem_cnt - 1;
            end
        end
        if (bus.imem_req && gnt) begin
            if (mem_busy) proto_err <= 1'b1;
            mem_addr <= bus.imem_addr;
            if (lat == 1) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= bus.imem_addr ^ K;
                mem_busy   <= 1'b0;
            end else begin
                mem_busy <= 1'b1;
                mem_cnt  <= lat - 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // One cycle: drive at negedge, sample 1ns later, before the next rising edge.
    task automatic step(input bit r, input bit st, input bit rd, input logic [31:0] tg,
                        input bit g, input int l, input bit e_req, input logic [31:0] e_addr,
                        input bit e_vld, input logic [31:0] e_pc);
        logic [31:0] e_ins, e_sum;
        @(negedge clk);
        rst = r; stall = st; redirect = rd; target = tg; gnt = g; lat = l;
        #1;
        e_ins = e_vld ? (e_pc ^ K) : 32'h0;
        e_sum = e_vld ? (e_pc + 32'd4) : 32'h0;
        chk($sformatf("c%0d.req", cyc), {31'b0, bus.imem_req}, {31'b0, e_req});
        if (e_req) chk($sformatf("c%0d.addr", cyc), bus.imem_addr, e_addr);
        chk($sformatf("c%0d.vld", cyc), {31'b0, vld}, {31'b0, e_vld});
        chk($sformatf("c%0d.pc", cyc), pc_o, e_vld ? e_pc : 32'h0);
        chk($sformatf("c%0d.ins", cyc), instr, e_ins);
        chk($sformatf("c%0d.sum", cyc), sum_o, e_sum);
        cyc++;
    endtask

    function automatic vec_t v(bit st, bit rd, logic [31:0] tg, bit g, int l,
                               bit er, logic [31:0] ea, bit ev, logic [31:0] ep);
        vec_t x;
        x.st = st; x.rd = rd; x.tg = tg; x.g = g; x.l = l;
        x.e_req = er; x.e_addr = ea; x.e_vld = ev; x.e_pc = ep;
        return x;
    endfunction

    initial begin
        // Free run, latency 1: first head in cycle 2, one per cycle.
        tbl.push_back(v(0,0,0,1,1, 1,32'h000, 0,0));
        tbl.push_back(v(0,0,0,1,1, 1,32'h004, 0,0));
        tbl.push_back(v(0,0,0,1,1, 1,32'h008, 1,32'h00));
        tbl.push_back(v(0,0,0,1,1, 1,32'h00C, 1,32'h04));
        tbl.push_back(v(0,0,0,1,1, 1,32'h010, 1,32'h08));
        tbl.push_back(v(0,0,0,1,1, 1,32'h014, 1,32'h0C));
        // Stall 5 cycles on head 0x10: request drops once two are buffered.
        tbl.push_back(v(1,0,0,1,1, 0,0, 1,32'h10));
        for (int i = 0; i < 4; i++) tbl.push_back(v(1,0,0,1,1, 0,0, 1,32'h10));
        tbl.push_back(v(0,0,0,1,1, 1,32'h018, 1,32'h10));
        tbl.push_back(v(0,0,0,1,1, 1,32'h01C, 1,32'h14));
        // Fill two, none outstanding, then redirect to 0x100.
        tbl.push_back(v(1,0,0,1,1, 0,0, 1,32'h18));
        tbl.push_back(v(0,1,32'h100,1,1, 0,0, 1,32'h18));
        tbl.push_back(v(0,0,0,1,1, 1,32'h100, 0,0));
        tbl.push_back(v(0,0,0,1,1, 1,32'h104, 0,0));
        tbl.push_back(v(0,0,0,1,1, 1,32'h108, 1,32'h100));
        tbl.push_back(v(0,0,0,1,1, 1,32'h10C, 1,32'h104));
        // Redirect with stall and a valid head, then grant withheld 4 cycles.
        tbl.push_back(v(1,1,32'h300,1,1, 0,0, 1,32'h108));
        for (int i = 0; i < 4; i++) tbl.push_back(v(0,0,0,0,1, 1,32'h300, 0,0));
        tbl.push_back(v(0,0,0,1,1, 1,32'h300, 0,0));
        tbl.push_back(v(0,0,0,1,1, 1,32'h304, 0,0));
        // Latency 3: redirect while in flight, again during kill; old word dropped.
        tbl.push_back(v(0,0,0,1,3, 1,32'h308, 1,32'h300));
        tbl.push_back(v(0,1,32'h280,1,3, 0,0, 1,32'h304));
        tbl.push_back(v(0,1,32'h200,1,3, 0,0, 0,0));
        tbl.push_back(v(0,0,0,1,3, 0,0, 0,0));
        tbl.push_back(v(0,0,0,1,3, 1,32'h200, 0,0));
        tbl.push_back(v(0,0,0,1,3, 0,0, 0,0));
        tbl.push_back(v(0,0,0,1,3, 0,0, 0,0));
        tbl.push_back(v(0,0,0,1,3, 1,32'h204, 0,0));
        tbl.push_back(v(0,0,0,1,3, 0,0, 1,32'h200));

        // Reset state.
        step(1,0,0,0,1,1, 0,0, 0,0);
        step(1,0,0,0,1,1, 0,0, 0,0);
        cyc = 0;
        foreach (tbl[i])
            step(0, tbl[i].st, tbl[i].rd, tbl[i].tg, tbl[i].g, tbl[i].l,
                 tbl[i].e_req, tbl[i].e_addr, tbl[i].e_vld, tbl[i].e_pc);

        // Reset with a request in flight; the late response must be ignored.
        step(1,0,0,0,1,2, 0,0, 0,0);
        step(1,0,0,0,1,2, 0,0, 0,0);
        step(0,0,0,0,1,2, 1,32'h0, 0,0);
        step(1,0,0,0,1,2, 0,0, 0,0);
        step(0,0,0,0,1,2, 1,32'h0, 0,0);
        step(0,0,0,0,1,2, 0,0, 0,0);
        step(0,0,0,0,1,2, 1,32'h4, 0,0);
        step(0,0,0,0,1,2, 0,0, 1,32'h0);
        // PC wrap from 0xFFFF_FFFC.
        step(0,0,1,32'hFFFF_FFFC,1,1, 0,0, 0,0);
        step(0,0,0,0,1,1, 1,32'hFFFF_FFFC, 0,0);
        step(0,0,0,0,1,1, 1,32'h0, 0,0);
        step(0,0,0,0,1,1, 1,32'h4, 1,32'hFFFF_FFFC);
        step(0,0,0,0,1,1, 1,32'h8, 1,32'h0);

        chk("proto_overlap", {31'b0, proto_err}, 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
